// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit: operation codes and FSM state encoding.
package mdu_ctrl_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV_ST = 2'd2
    } mdu_state_e;

    // True for the four operations that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit: computes the result at start, holds it hidden
// while busy counts down, then commits it to HI/LO in one step.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [63:0]      res_q, res_d;

    logic signed [63:0] a_sx, b_sx;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        abs_a, abs_b, quo_u, rem_u, quo_s, rem_s, quo_uu, rem_uu;

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign abs_a  = a[31] ? (~a + 32'd1) : a;
    assign abs_b  = b[31] ? (~b + 32'd1) : b;
    assign quo_u  = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
    assign rem_u  = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
    assign quo_s  = (a[31] ^ b[31]) ? (~quo_u + 32'd1) : quo_u;
    assign rem_s  = a[31] ? (~rem_u + 32'd1) : rem_u;
    assign quo_uu = (b == 32'd0) ? 32'd0 : a / b;
    assign rem_uu = (b == 32'd0) ? 32'd0 : a % b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            res_d   = (op == MDU_MULT) ? prod_s : prod_u;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = MDU_MUL;
                            busy_d  = 1'b1;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            // A zero divisor latches the current HI/LO so the commit is a no-op.
                            if (b == 32'd0)
                                res_d = {hi_q, lo_q};
                            else if (op == MDU_DIV)
                                res_d = {rem_s, quo_s};
                            else
                                res_d = {rem_uu, quo_uu};
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = MDU_DIV_ST;
                            busy_d  = 1'b1;
                        end
                        MDU_MTHI: hi_d = a;
                        MDU_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            default: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res_q[63:32];
                    lo_d    = res_q[31:0];
                    state_d = MDU_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = md_use_d & (busy_q | (start & is_muldiv(op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed corner cases plus random operations against an
// arithmetic reference model of HI/LO.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        md_use_d = 1'b0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_use_d(md_use_d), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: what HI/LO hold after an operation completes, from plain arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint sx, sy, p, q, r;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MDU_MULT:  begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            MDU_MULTU: begin up = ux * uy; h = up[63:32]; l = up[31:0]; end
            MDU_DIV:   if (y != 0) begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
            MDU_DIVU:  if (y != 0) begin h = x % y; l = x / y; end
            MDU_MTHI:  h = x;
            MDU_MTLO:  l = x;
            default: ;
        endcase
    endfunction

    function automatic int op_len(input logic [2:0] o);
        if (o == MDU_MULT || o == MDU_MULTU) return MC;
        if (o == MDU_DIV || o == MDU_DIVU) return DC;
        return 0;
    endfunction

    // Issue one op at a negedge and follow it to completion, checking every cycle.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic md, input logic inject);
        int n;
        logic [31:0] h_old, l_old;
        n = op_len(o);
        h_old = hi_m;
        l_old = lo_m;
        model(o, x, y, hi_m, lo_m);
        op = o; a = x; b = y; md_use_d = md; start = 1'b1;
        #1;
        total_cnt++;
        if (stall_req !== (md & (n != 0))) $display("FAIL %s stall_at_start got=%b exp=%b", name, stall_req, md & (n != 0));
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            total_cnt++;
            if (busy !== 1'b1 || hi !== h_old || lo !== l_old || stall_req !== md)
                $display("FAIL %s busy_cyc%0d got busy=%b stall=%b hi=%h lo=%h exp busy=1 stall=%b hi=%h lo=%h",
                         name, i, busy, stall_req, hi, lo, md, h_old, l_old);
            else pass_cnt++;
            if (inject && i == 1) begin
                start = 1'b1; op = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m || stall_req !== 1'b0)
            $display("FAIL %s done got busy=%b stall=%b hi=%h lo=%h exp busy=0 stall=0 hi=%h lo=%h",
                     name, busy, stall_req, hi, lo, hi_m, lo_m);
        else pass_cnt++;
        md_use_d = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_req !== 1'b0)
            $display("FAIL reset_state got busy=%b hi=%h lo=%h stall=%b exp 0/0/0/0", busy, hi, lo, stall_req);
        else pass_cnt++;
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        @(negedge clk);
    endtask

    task automatic test_mult;
        run_op("mult_neg1x2", MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        total_cnt++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) $display("FAIL mult_const got hi=%h lo=%h exp hi=ffffffff lo=fffffffe", hi, lo);
        else pass_cnt++;
        run_op("multu_ffx2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        total_cnt++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) $display("FAIL multu_const got hi=%h lo=%h exp hi=00000001 lo=fffffffe", hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_div;
        run_op("div_m7_2", MDU_DIV, -32'sd7, 32'd2, 1'b0, 1'b0);
        total_cnt++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) $display("FAIL div_const got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo);
        else pass_cnt++;
        run_op("divu_by0", MDU_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
        total_cnt++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) $display("FAIL divu0_hold got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo);
        else pass_cnt++;
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) $display("FAIL div_ovf_const got hi=%h lo=%h exp hi=00000000 lo=80000000", hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_stall;
        run_op("mult_stall", MDU_MULT, 32'd1234, 32'hFFFF_FF00, 1'b1, 1'b1);
        run_op("divu_stall", MDU_DIVU, 32'hDEAD_BEEF, 32'd77, 1'b1, 1'b1);
    endtask

    task automatic test_mt_and_reset;
        run_op("mthi", MDU_MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        total_cnt++;
        if (hi !== 32'h1234_5678) $display("FAIL mthi_const got hi=%h exp 12345678", hi);
        else pass_cnt++;
        run_op("mtlo", MDU_MTLO, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);
        op = MDU_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL reset_mid_div got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        repeat (DC + 2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL after_release got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
        else pass_cnt++;
        run_op("first_after_reset", MDU_MULTU, 32'd300, 32'd5, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [2:0] o;
        logic [31:0] x, y;
        for (int k = 0; k < 40; k++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
            run_op($sformatf("rand%0d_op%0d", k, o), o, x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back_stall();
        test_mt_and_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
